// File: rtl/gpio_peripheral.sv
// GPIO peripheral: a registered output port written from the core bus, and an input port
// read back through a 2-flop synchronizer and an optional per-word debouncer.
// Optional feature macro: GPIO_DEBOUNCE_EN. When it is defined, input changes must be stable
// for DEBOUNCE_CYCLES synchronized samples before they reach gpio_rddata. When it is not
// defined, gpio_rddata shows the synchronizer output directly.
module gpio_peripheral #(
  parameter int unsigned IN_WIDTH        = 8,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gpio_wren,
  input  logic [31:0]          bus_wrdata,
  output logic [31:0]          gpio_rddata,
  input  logic [IN_WIDTH-1:0]  pins_in,
  output logic [OUT_WIDTH-1:0] pins_out
);

  // ---------------------------------------------------------------------------
  // Output port
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] out_q;

  // Load the low OUT_WIDTH bits of the store data on a write strobe, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (gpio_wren) begin
      out_q <= bus_wrdata[OUT_WIDTH-1:0];
    end
  end

  assign pins_out = out_q;

  // Store-data bits above OUT_WIDTH are discarded by design.
  logic unused_wrdata;
  assign unused_wrdata = ^(bus_wrdata >> OUT_WIDTH);

  // ---------------------------------------------------------------------------
  // Input synchronizer: the only logic that touches the asynchronous pins.
  // ---------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] sync1_q;
  logic [IN_WIDTH-1:0] sync2_q;

  // Two-stage metastability filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins_in;
      sync2_q <= sync1_q;
    end
  end

  // Value presented on the read port, before zero-extension.
  logic [IN_WIDTH-1:0] rd_value;

`ifdef GPIO_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debouncer: a candidate word must be seen on DEBOUNCE_CYCLES consecutive
  // synchronized samples before it replaces the accepted (stable) word.
  // ---------------------------------------------------------------------------
  localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    StIdle,
    StCount
  } state_e;

  state_e              state_q;
  logic [IN_WIDTH-1:0] stable_q;
  logic [IN_WIDTH-1:0] cand_q;
  logic [15:0]         cnt_q;

  // Debounce FSM: track a candidate, restart on a new value, drop it on a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sync2_q != stable_q) begin
            cand_q  <= sync2_q;
            cnt_q   <= 16'd1;
            state_q <= StCount;
          end else begin
            cnt_q <= '0;
          end
        end
        StCount: begin
          if (sync2_q == stable_q) begin
            // Input fell back to the accepted value: glitch rejected.
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (sync2_q != cand_q) begin
            // A different new value: restart the run from this sample.
            cand_q <= sync2_q;
            cnt_q  <= 16'd1;
          end else if (cnt_q == CntMax) begin
            stable_q <= cand_q;
            cnt_q    <= '0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_value = stable_q;
`else
  // No debouncer: the read port follows the synchronizer with a 2-edge latency.
  assign rd_value = sync2_q;
`endif

  // Combinational read data so a single-cycle load sees the current value.
  always_comb begin
    gpio_rddata = '0;
    gpio_rddata[IN_WIDTH-1:0] = rd_value;
  end

endmodule

// File: tb/tb_gpio_peripheral.sv
// Self-checking bench for gpio_peripheral (8-bit ports, DEBOUNCE_CYCLES = 4).
// Works in both builds; expectations follow GPIO_DEBOUNCE_EN when it is defined.
module tb_gpio_peripheral;

  localparam int Deb = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int Lat = Deb + 2;
`else
  localparam int Lat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        gpio_wren;
  logic [31:0] bus_wrdata;
  logic [31:0] gpio_rddata;
  logic [7:0]  pins_in;
  logic [7:0]  pins_out;

  int n_checks = 0;
  int n_errors = 0;

  gpio_peripheral #(
    .IN_WIDTH       (8),
    .OUT_WIDTH      (8),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_wren  (gpio_wren),
    .bus_wrdata (bus_wrdata),
    .gpio_rddata(gpio_rddata),
    .pins_in    (pins_in),
    .pins_out   (pins_out)
  );

  always #5 clk = ~clk;

  // Reference model: a pin delay line plus a run-length acceptance rule.
  logic [7:0] m_out;
  logic [7:0] m_pipe [2];   // [0] = one edge old, [1] = two edges old
  logic [7:0] m_stable;
  logic [7:0] m_run_val;
  int         m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd();
`ifdef GPIO_DEBOUNCE_EN
    return {24'h0, m_stable};
`else
    return {24'h0, m_pipe[1]};
`endif
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [31:0] d,
                            input logic [7:0] p);
    if (r) begin
      m_out = '0; m_pipe[0] = '0; m_pipe[1] = '0;
      m_stable = '0; m_run_val = '0; m_run = 0;
    end else begin
      // Sample seen by the debouncer this edge is the two-edge-old pin value.
      if (m_pipe[1] == m_stable) begin
        m_run = 0;
      end else if (m_run > 0 && m_pipe[1] == m_run_val) begin
        m_run++;
      end else begin
        m_run_val = m_pipe[1];
        m_run = 1;
      end
      if (m_run == Deb) begin
        m_stable = m_run_val;
        m_run = 0;
      end
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = p;
      if (w) m_out = d[7:0];
    end
  endtask

  // One clock: drive, advance the model, then compare both outputs after the edge.
  task automatic step(input logic r, input logic w, input logic [31:0] d, input logic [7:0] p);
    rst = r; gpio_wren = w; bus_wrdata = d; pins_in = p;
    @(posedge clk);
    model_edge(r, w, d, p);
    #1;
    check("model_pins_out", {24'h0, pins_out}, {24'h0, m_out});
    check("model_rddata", gpio_rddata, model_rd());
  endtask

  typedef struct {
    logic        wren;
    logic [31:0] data;
    logic [7:0]  exp_out;
  } wr_vec_t;

  wr_vec_t tbl [6];

  initial begin
    logic [7:0] rp;
    int         hold;

    tbl[0] = '{1'b1, 32'hFFFF_FFA5, 8'hA5};
    tbl[1] = '{1'b0, 32'h0000_0000, 8'hA5};
    tbl[2] = '{1'b0, 32'h1234_5678, 8'hA5};
    tbl[3] = '{1'b1, 32'h0000_0100, 8'h00};
    tbl[4] = '{1'b1, 32'hDEAD_BE3C, 8'h3C};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF, 8'h3C};

    rst = 1'b1; gpio_wren = 1'b0; bus_wrdata = '0; pins_in = '0;
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
    step(1'b1, 1'b0, 32'h0, 8'h00);
    check("reset_pins_out", {24'h0, pins_out}, 32'h0);
    check("reset_rddata", gpio_rddata, 32'h0);

    // Write path vectors.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, tbl[i].wren, tbl[i].data, 8'h00);
      check("tbl_pins_out", {24'h0, pins_out}, {24'h0, tbl[i].exp_out});
    end

    // Held input change: invisible until exactly Lat edges, then visible.
    step(1'b1, 1'b0, 32'h0, 8'h00);
    for (int k = 1; k <= Lat + 1; k++) begin
      step(1'b0, 1'b0, 32'h0, 8'h3C);
      if (k < Lat) check("latency_before", gpio_rddata, 32'h0);
      else         check("latency_after", gpio_rddata, 32'h0000_003C);
    end

    // Two-cycle pulse: rejected by the debouncer.
    step(1'b1, 1'b0, 32'h0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 32'h0, (k <= 2) ? 8'h01 : 8'h00);
`ifdef GPIO_DEBOUNCE_EN
      check("glitch_rejected", gpio_rddata, 32'h0);
`endif
    end

    // Value changes mid-count: only the second value is ever accepted.
    step(1'b1, 1'b0, 32'h0, 8'h00);
    step(1'b0, 1'b0, 32'h0, 8'h01);
    step(1'b0, 1'b0, 32'h0, 8'h01);
    for (int k = 1; k <= Lat + 2; k++) begin
      step(1'b0, 1'b0, 32'h0, 8'h02);
`ifdef GPIO_DEBOUNCE_EN
      if (k < Lat) check("restart_before", gpio_rddata, 32'h0);
      else         check("restart_after", gpio_rddata, 32'h2);
`endif
    end

    // Reset mid-count (cnt = 2 after the 4th edge) abandons the pending value; reset beats write.
    step(1'b1, 1'b0, 32'h0, 8'h00);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 32'h0, 8'h01);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 8'h00);
    check("rst_mid_pins_out", {24'h0, pins_out}, 32'h0);
    check("rst_mid_rddata", gpio_rddata, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 8'h00);
      check("rst_mid_never", gpio_rddata, 32'h0);
    end

    // Simultaneous write and input change, 0x81 pattern.
    for (int k = 1; k <= Lat; k++) begin
      step(1'b0, (k == 1), 32'h0000_0055, 8'h81);
      check("simul_pins_out", {24'h0, pins_out}, 32'h55);
      if (k < Lat) check("simul_rd_before", gpio_rddata, 32'h0);
      else         check("simul_rd_after", gpio_rddata, 32'h81);
    end

    // Randomized traffic against the model.
    rp = 8'h00;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        // Bias towards few bit flips so both glitches and accepted values occur.
        rp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (rp ^ (8'h1 << $urandom_range(0, 7)));
        hold = $urandom_range(1, 8);
      end
      hold--;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), $urandom, rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
